// File: rtl/dma_pkg.sv
// Purpose: shared state encoding and default sizing for the DMA write controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int DEF_TOTAL_WORDS = 12;
  localparam int DEF_BURST_WORDS = 4;
  localparam int DEF_MEM_LATENCY = 4;
  localparam int BURSTS          = DEF_TOTAL_WORDS / DEF_BURST_WORDS;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_latency_timer.sv
// Purpose: loadable down-counter timing how long a burst is held on the memory port.
// Latency: last is combinational from the count; load takes effect next cycle.
// Backpressure: none; counts down only while en is high and stops at zero.
module dma_latency_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise decrement while enabled, saturating at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/dma_write_controller.sv
// Purpose: bus master moving one fixed-length job of device bursts into data memory, then interrupting the CPU.
// Latency: bus_request one cycle after cmd; write starts 2 cycles after grant; each burst = 1 fetch + MEM_LATENCY write cycles.
// Backpressure: waits in REQ for grant and in FETCH for dev_valid; grant loss honoured only between bursts.
module dma_write_controller
  import dma_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int TOTAL_WORDS = DEF_TOTAL_WORDS,
  parameter int BURST_WORDS = DEF_BURST_WORDS,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              cmd_valid,
  input  logic [ADDR_WIDTH-1:0]             cmd_addr,
  output logic                              cmd_ready,
  output logic                              bus_request,
  input  logic                              bus_grant,
  input  logic                              dev_valid,
  input  logic [BURST_WORDS*WORD_WIDTH-1:0] dev_data,
  output logic                              dev_pop,
  output logic                              mem_write,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [BURST_WORDS*WORD_WIDTH-1:0] mem_data,
  output logic                              busy,
  output logic                              dma_end
);

  localparam int NBURSTS = TOTAL_WORDS / BURST_WORDS;
  localparam int LAT_W   = cnt_width(MEM_LATENCY);
  localparam int BC_W    = cnt_width(NBURSTS + 1);

  state_t          state;
  state_t          next_state;
  logic [BC_W-1:0] burst_cnt;
  logic            lat_last;
  logic            fetch_go;
  logic            burst_end;

  dma_latency_timer #(
    .WIDTH (LAT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (fetch_go),
    .load_val (LAT_W'(MEM_LATENCY - 1)),
    .en       (state == WRITE),
    .last     (lat_last)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the fetch and end-of-burst strobes.
  always_comb begin
    next_state = state;
    fetch_go   = 1'b0;
    burst_end  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) next_state = REQ;
      end
      REQ: begin
        if (bus_grant) next_state = FETCH;
      end
      FETCH: begin
        if (dev_valid && bus_grant) begin
          fetch_go   = 1'b1;
          next_state = WRITE;
        end else if (!bus_grant) begin
          next_state = REQ;
        end
      end
      WRITE: begin
        if (lat_last) begin
          burst_end  = 1'b1;
          next_state = (burst_cnt == BC_W'(NBURSTS - 1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address register, burst counter and payload register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      burst_cnt <= '0;
      mem_data  <= '0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        mem_addr  <= cmd_addr;
        burst_cnt <= '0;
      end else if (burst_end) begin
        mem_addr  <= mem_addr + ADDR_WIDTH'(BURST_WORDS);
        burst_cnt <= burst_cnt + 1'b1;
      end
      if (fetch_go) mem_data <= dev_data;
    end
  end

  // Control outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      bus_request <= 1'b0;
      mem_write   <= 1'b0;
      dev_pop     <= 1'b0;
      dma_end     <= 1'b0;
    end else begin
      cmd_ready   <= (next_state == IDLE);
      busy        <= (next_state != IDLE);
      bus_request <= (next_state == REQ) || (next_state == FETCH) || (next_state == WRITE);
      mem_write   <= (next_state == WRITE);
      dev_pop     <= fetch_go;
      dma_end     <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_dma_write_controller.sv
// Purpose: scoreboard bench for dma_write_controller covering nominal, stalls, grant loss, wrap and reset abort.
// Latency: expected bursts queued at command time, compared as each write burst begins.
// Backpressure: bench drives bus_grant and dev_valid to exercise REQ and FETCH waits.
module tb_dma_write_controller;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic [15:0] cmd_addr;
  logic        cmd_ready;
  logic        bus_request;
  logic        bus_grant;
  logic        dev_valid;
  logic [63:0] dev_data;
  logic        dev_pop;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_data;
  logic        busy;
  logic        dma_end;

  dma_write_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_addr    (cmd_addr),
    .cmd_ready   (cmd_ready),
    .bus_request (bus_request),
    .bus_grant   (bus_grant),
    .dev_valid   (dev_valid),
    .dev_data    (dev_data),
    .dev_pop     (dev_pop),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .busy        (busy),
    .dma_end     (dma_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  int ends     = 0;
  int dev_idx  = 0;
  int pop_snap = 0;
  int end_snap = 0;
  logic mon_en = 1'b0;

  // Device burst n: four distinct words derived from the burst index.
  function automatic logic [63:0] pat(input int n);
    logic [63:0] v;
    v = '0;
    for (int w = 0; w < 4; w++) v[w*16 +: 16] = 16'(32'h5A00 + n * 17 + w * 3);
    return v;
  endfunction

  assign dev_data = pat(dev_idx);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: device advance on pop, scoreboard compare at write start, burst length and stability.
  logic       prev_wr  = 1'b0;
  logic       prev_req = 1'b0;
  int         wr_len   = 0;
  logic       stable   = 1'b1;
  logic [15:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  exp_t        e_pop;
  always @(negedge clk) begin
    if (dev_pop) dev_idx = dev_idx + 1;
    if (mon_en) begin
      if (dev_pop) pops++;
      if (dma_end) begin
        ends++;
        chk("dma_end_with_req_fall", {62'd0, prev_req, bus_request}, 64'd2);
      end
      if (mem_write && !prev_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          e_pop = exp_q.pop_front();
          chk("burst_addr", {48'd0, mem_addr}, {48'd0, e_pop.addr});
          chk("burst_data", mem_data, e_pop.data);
        end
        wr_len  = 1;
        wr_addr = mem_addr;
        wr_data = mem_data;
        stable  = 1'b1;
      end else if (mem_write) begin
        wr_len++;
        if (mem_addr !== wr_addr || mem_data !== wr_data) stable = 1'b0;
      end
      if (!mem_write && prev_wr) begin
        chk("write_len", 64'(wr_len), 64'd4);
        chk("write_stable", {63'd0, stable}, 64'd1);
      end
      prev_wr  = mem_write;
      prev_req = bus_request;
    end else begin
      prev_wr  = 1'b0;
      prev_req = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input logic [15:0] a);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      e.addr = a + 16'(4 * k);
      e.data = pat(dev_idx + k);
      exp_q.push_back(e);
    end
    pop_snap  = pops;
    end_snap  = ends;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (bus_request) break;
      step();
    end
    chk("req_seen", {63'd0, bus_request}, 64'd1);
  endtask

  task automatic wait_wr(input logic want);
    for (int i = 0; i < 100; i++) begin
      if (mem_write == want) break;
      step();
    end
    chk("mem_write_reached", {63'd0, mem_write}, {63'd0, want});
  endtask

  task automatic wait_pops(input int n);
    for (int i = 0; i < 100; i++) begin
      if (pops - pop_snap >= n) break;
      step();
    end
    chk("pops_reached", 64'(pops - pop_snap), 64'(n));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      step();
      if (ends != end_snap) break;
    end
    chk("job_dma_end", 64'(ends - end_snap), 64'd1);
    chk("job_pops", 64'(pops - pop_snap), 64'd3);
    chk("job_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    exp_q.delete();
  endtask

  logic viol;
  int   cyc;

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    bus_grant = 1'b0;
    dev_valid = 1'b1;
    repeat (3) step();
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_bus_request", {63'd0, bus_request}, 64'd0);
    chk("rst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("rst_dev_pop", {63'd0, dev_pop}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_dma_end", {63'd0, dma_end}, 64'd0);
    chk("rst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("rst_mem_data", mem_data, 64'd0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();

    // Nominal job, grant two cycles after the request.
    start_job(16'h0017);
    wait_req();
    step();
    step();
    bus_grant = 1'b1;
    wait_done();
    bus_grant = 1'b0;
    step();

    // Grant withheld for 20 cycles.
    start_job(16'h0040);
    wait_req();
    viol = 1'b0;
    repeat (20) begin
      step();
      if (!bus_request || mem_write || dev_pop) viol = 1'b1;
    end
    chk("grant_wait_hold", {63'd0, viol}, 64'd0);
    bus_grant = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      cyc = c;
      if (mem_write) break;
    end
    chk("grant_to_write_cycles", 64'(cyc), 64'd2);
    wait_done();
    step();

    // Device stall before burst 2.
    start_job(16'h0017);
    wait_pops(1);
    dev_valid = 1'b0;
    wait_wr(1'b0);
    viol = 1'b0;
    repeat (5) begin
      step();
      if (!bus_request || mem_write || dev_pop) viol = 1'b1;
    end
    chk("stall_hold", {63'd0, viol}, 64'd0);
    dev_valid = 1'b1;
    wait_done();
    step();

    // Grant withdrawn during burst 1.
    start_job(16'h0300);
    wait_wr(1'b1);
    bus_grant = 1'b0;
    wait_wr(1'b0);
    viol = 1'b0;
    repeat (6) begin
      step();
      if (!bus_request || mem_write || dev_pop) viol = 1'b1;
    end
    chk("grant_loss_hold", {63'd0, viol}, 64'd0);
    bus_grant = 1'b1;
    wait_done();
    step();

    // Address wrap.
    start_job(16'hFFFC);
    wait_done();
    step();

    // Command while busy is neither applied nor queued.
    start_job(16'h0100);
    wait_wr(1'b1);
    cmd_addr  = 16'h0800;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_done();
    repeat (4) step();
    chk("no_queued_cmd", {62'd0, bus_request, busy}, 64'd0);

    // Reset during the write of burst 2.
    start_job(16'h0200);
    wait_pops(2);
    chk("reset_in_write", {63'd0, mem_write}, 64'd1);
    #1;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("arst_bus_request", {63'd0, bus_request}, 64'd0);
    chk("arst_mem_write", {63'd0, mem_write}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("arst_dev_pop", {63'd0, dev_pop}, 64'd0);
    chk("arst_mem_addr", {48'd0, mem_addr}, 64'd0);
    chk("arst_mem_data", mem_data, 64'd0);
    viol = 1'b0;
    repeat (3) begin
      step();
      if (dma_end) viol = 1'b1;
    end
    reset_n = 1'b1;
    exp_q.delete();
    end_snap = ends;
    mon_en   = 1'b1;
    repeat (10) begin
      step();
      if (dma_end) viol = 1'b1;
    end
    chk("no_dma_end_after_reset", {63'd0, viol}, 64'd0);
    chk("no_dma_end_count", 64'(ends - end_snap), 64'd0);
    chk("idle_after_reset", {62'd0, bus_request, mem_write}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_write_controller.md
Name: dma_write_controller

Overview:
- Bus-master side of the CPU/DMA memory-sharing handshake.
- On a CPU start command, the block requests the memory bus, waits for grant and moves a fixed-length block of device words into data memory in fixed-size bursts.
- It then releases the bus and interrupts the CPU.
- The CPU pipeline stalls on memory access while bus_grant is high; this block is the party that holds the bus during that time.

Parameters:
- WORD_WIDTH, 16, bits per memory word
- ADDR_WIDTH, 16, memory word-address width
- TOTAL_WORDS, 12, words per DMA job; must be a multiple of BURST_WORDS
- BURST_WORDS, 4, words per memory write burst
- MEM_LATENCY, 4, cycles a burst write is held on the memory port; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  CPU start request, sampled only in IDLE
- cmd_addr  in  ADDR_WIDTH  destination base word address
- cmd_ready  out  1  high only in IDLE
- bus_request  out  1  request for memory bus ownership
- bus_grant  in  1  arbiter/CPU grant; CPU access_mem = !bus_grant
- dev_valid  in  1  device has a full burst available on dev_data
- dev_data  in  BURST_WORDS*WORD_WIDTH  burst payload, word 0 in LSBs
- dev_pop  out  1  one-cycle pulse; device advances to next burst
- mem_write  out  1  burst write strobe to data memory
- mem_addr  out  ADDR_WIDTH  burst base address
- mem_data  out  BURST_WORDS*WORD_WIDTH  registered burst payload
- busy  out  1  high in every state except IDLE
- dma_end  out  1  one-cycle completion interrupt

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; cmd_ready = 1.
  - bus_request, mem_write, dev_pop, busy and dma_end all 0.
  - mem_addr, mem_data and all counters 0.
  - Reset mid-job aborts the job immediately. bus_request drops in the same cycle reset asserts. No dma_end is produced.
- All outputs are registered.
- States: IDLE, REQ, FETCH, WRITE, DONE.
- IDLE:
  - On cmd_valid=1, latch cmd_addr into the address register, clear the burst counter and go to REQ.
  - bus_request rises on the cycle after cmd_valid is sampled.
- REQ:
  - bus_request=1.
  - When bus_grant=1 is sampled, go to FETCH.
  - bus_request stays high indefinitely while the grant is absent.
- FETCH:
  - bus_request=1.
  - When both dev_valid=1 and bus_grant=1: register dev_data into mem_data, pulse dev_pop for 1 cycle, load the latency counter with MEM_LATENCY-1, and go to WRITE.
  - If bus_grant=0, return to REQ. Grant loss is honoured only at burst boundaries.
- WRITE:
  - mem_write=1, with mem_addr and mem_data held stable for exactly MEM_LATENCY cycles. bus_grant is ignored here; the burst always completes.
  - On the last cycle:
    - mem_addr += BURST_WORDS (modulo 2^ADDR_WIDTH, so wrap is silent).
    - Burst counter increments.
    - If the burst counter reaches TOTAL_WORDS/BURST_WORDS, go to DONE; otherwise go to FETCH.
  - mem_write is deasserted in the cycle after WRITE ends.
- DONE:
  - One cycle long. bus_request=0 and dma_end=1 in this cycle, then go to IDLE.
  - cmd_ready returns to 1 on the following cycle.
- Overlap rules:
  - cmd_valid while busy is ignored and not queued.
  - cmd_valid in the same cycle as DONE is ignored.
- Total grant-held cycles for the defaults, with device always ready:
  - Each burst costs 1 FETCH cycle plus 4 WRITE cycles.
  - 3 bursts = 15 cycles, plus the DONE cycle.

Decomposition:
- Shared package dma_pkg:
  - State enum (IDLE/REQ/FETCH/WRITE/DONE).
  - Default WORD_WIDTH, BURST_WORDS, TOTAL_WORDS and MEM_LATENCY constants.
  - A derived BURSTS constant.
- One natural sub-module, dma_latency_timer:
  - Loadable down-counter.
  - Asserts `last` when the count is 0.
  - Used by the WRITE state.
- The burst counter and address register stay in the top module.

Test Plan:
- Nominal job:
  - Stimulus: cmd_valid with cmd_addr=0x0017; bus_grant raised 2 cycles after bus_request; dev_valid held 1.
  - Required: three bursts at mem_addr 0x0017, 0x001B, 0x001F. Each burst has mem_write high for exactly 4 cycles with mem_data equal to the popped dev_data. dev_pop pulses exactly 3 times. dma_end pulses once, coincident with bus_request falling.
- Grant delay:
  - Stimulus: bus_grant held 0 for 20 cycles after the request.
  - Required: bus_request stays 1, mem_write stays 0 and dev_pop stays 0 throughout. The first write starts 2 cycles after bus_grant rises.
- Device stall:
  - Stimulus: dev_valid drops for 5 cycles before burst 2.
  - Required: FETCH holds, bus_request stays 1 and no write occurs. The burst resumes with the correct address 0x001B.
- Grant withdrawal:
  - Stimulus: bus_grant dropped mid-burst 1.
  - Required: burst 1 completes all 4 cycles, then the controller returns to REQ. Burst 2 starts only after the grant is reasserted.
- Address wrap:
  - Stimulus: cmd_addr=0xFFFC.
  - Required: bursts at 0xFFFC, 0x0000, 0x0004.
- Reset and ignored command:
  - Stimulus: reset_n pulsed low during the WRITE of burst 2; then cmd_valid pulsed while busy.
  - Required: on reset, all outputs go to 0 asynchronously, cmd_ready goes to 1 and no dma_end occurs. Separately, a cmd_valid issued while busy does not alter the addresses of the current job.
